// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter:
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   BEAT_CNT_W  : width of the per-grant beat counter
//   clog2()     : constant ceiling-log2 used to size producer indices
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 8;

  // Ceiling log2, evaluated at elaboration time to size index buses.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector.
//   i_req        : request vector, one bit per producer
//   i_last_grant : index of the most recently granted producer
//   o_any_req    : at least one request is pending
//   o_winner     : first requesting index strictly after i_last_grant,
//                  wrapping modulo NUM_REQ (valid only when o_any_req)
// ---------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic               o_any_req,
  output logic [IDX_W-1:0]   o_winner
);

  logic w_found;
  int   w_idx;

  // Walk the producers starting one past the last grant; the modulo keeps
  // the wrap correct when NUM_REQ is not a power of two.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = 0;
    o_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        o_winner = IDX_W'(w_idx);
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A producer is granted for up to BURST_LEN beats; every write is gated by
// the FIFO full flag, and almost_full throttles grants to a single beat.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_data : per-producer valid and packed data
//   req_ready          : per-producer accept (at most one bit set)
//   fifo_full          : FIFO full flag, blocks writes in the same cycle
//   fifo_almost_full   : FIFO almost-full flag, ends a grant after one beat
//   fifo_wr_en/_data   : FIFO write port (data is zero when not writing)
//   grant_active       : registered, high while in GRANT
//   grant_id           : registered, current or last granted producer
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_active,
  output logic [clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int                    IDX_W      = clog2(NUM_REQ);
  localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(BURST_LEN);

  arb_state_e              r_state;
  arb_state_e              w_next_state;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic [BEAT_CNT_W-1:0]   w_beat_next;
  logic [IDX_W-1:0]        r_grant_id;
  logic [IDX_W-1:0]        r_last_grant;
  logic                    r_grant_active;
  logic                    w_any_req;
  logic [IDX_W-1:0]        w_winner;
  logic                    w_cur_valid;
  logic [DATA_WIDTH-1:0]   w_cur_data;
  logic                    w_beat_accept;
  logic                    w_burst_done;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_any_req    (w_any_req),
    .o_winner     (w_winner)
  );

  assign w_cur_valid   = req_valid[r_grant_id];
  assign w_cur_data    = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_beat_accept = (r_state == GRANT) && w_cur_valid && !fifo_full;
  assign w_beat_next   = r_beat_cnt + 8'd1;
  assign w_burst_done  = (w_beat_next == BURST_LAST);

  // Next-state and write-port decode. Ready follows only the full flag, so a
  // granted producer sees ready even before it raises valid; the write itself
  // needs both. The grant ends on a full burst, on an almost-full accept, or
  // as soon as the owner drops valid.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next_state = GRANT;
        end
      end
      GRANT: begin
        req_ready[r_grant_id] = !fifo_full;
        fifo_wr_en            = w_beat_accept;
        if (w_beat_accept) begin
          fifo_wr_data = w_cur_data;
        end
        if (w_beat_accept && (w_burst_done || fifo_almost_full)) begin
          w_next_state = IDLE;
        end else if (!w_cur_valid) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and beat counter. last_grant resets to the top
  // index so that producer 0 is the first winner out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_beat_cnt     <= '0;
      r_grant_id     <= '0;
      r_last_grant   <= IDX_W'(NUM_REQ - 1);
      r_grant_active <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_grant_active <= (w_next_state == GRANT);
      if ((r_state == IDLE) && w_any_req) begin
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
        r_beat_cnt   <= '0;
      end else if (w_beat_accept) begin
        r_beat_cnt   <= w_beat_next;
      end
    end
  end

  assign grant_active = r_grant_active;
  assign grant_id     = r_grant_id;

endmodule
